nn_backprop_core: RTL and testbench

//  2-2-2 fully connected neural net (2 inputs, 2 sigmoid hidden, 2 sigmoid outputs) with on-chip backprop training.

---
 rtl/nn_backprop_core_if.sv | 19 +
 rtl/nn_backprop_core.sv | 249 ++++++++++++++++++++++++
 tb/tb_nn_backprop_core.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nn_backprop_core_if.sv
// rtl/nn_backprop_core_if.sv - host-side signal bundle for the nn_backprop_core training engine
interface nn_backprop_core_if;
  logic        update_coeff;
  logic [15:0] input_k_1;
  logic [15:0] input_k_2;
  logic        finish_updating;
  logic [15:0] a3_1;
  logic [15:0] a3_2;

  modport master (
    output update_coeff, input_k_1, input_k_2,
    input  finish_updating, a3_1, a3_2
  );

  modport slave (
    input  update_coeff, input_k_1, input_k_2,
    output finish_updating, a3_1, a3_2
  );
endinterface

// File: rtl/nn_backprop_core.sv
// rtl/nn_backprop_core.sv - 2-2-2 sigmoid net with on-chip backprop, Q2.14, 13-cycle iterations
// Define NN_SATURATION_EN to clamp products, sums and weight writes to the 16-bit range.
module nn_backprop_core #(
  parameter logic signed [15:0] T1       = 16'sh3000,
  parameter logic signed [15:0] T2       = 16'sh1000,
  parameter int                 LR_SHIFT = 2,
  parameter logic signed [15:0] ERR_TH   = 16'sh0100,
  parameter int                 MAX_ITER = 10000
) (
  input logic               clk,
  input logic               res,
  nn_backprop_core_if.slave host
);

  localparam int CW = $clog2(MAX_ITER + 1);

  typedef logic signed [15:0] q16_t;
  typedef logic signed [19:0] q20_t;

  typedef enum logic [3:0] {
    S0_LOAD, S1_Z2, S2_A2, S3_Z3, S4_A3, S5_ERR, S6_D3P, S7_D3,
    S8_D2P, S9_D2, S10_UW2, S11_UW1, S12_CHK, S13_DONE
  } state_t;

  localparam q16_t ONE = 16'sh4000;

  function automatic q20_t clip(logic signed [31:0] v);
`ifdef NN_SATURATION_EN
    if (v > 32'sd32767) return 20'sd32767;
    else if (v < -32'sd32768) return -20'sd32768;
    else return 20'(v);
`else
    return 20'(v);
`endif
  endfunction

  function automatic q20_t ext(q16_t v);
    return 20'(v);
  endfunction

  function automatic q16_t n16(q20_t v);
    return 16'(v);
  endfunction

  function automatic q20_t mulq(q16_t a, q16_t b);
    logic signed [31:0] p;
    p = 32'(a) * 32'(b);
    return clip(p >>> 14);
  endfunction

  function automatic q20_t add3(q20_t a, q20_t b, q20_t c);
    return clip(32'(a) + 32'(b) + 32'(c));
  endfunction

  function automatic q20_t sub2(q20_t a, q20_t b);
    return clip(32'(a) - 32'(b));
  endfunction

  function automatic q20_t absq(q16_t v);
    q20_t e;
    e = ext(v);
    return e[19] ? -e : e;
  endfunction

  // Piecewise-linear sigmoid on |z|, mirrored about 0.5 for negative z
  function automatic q16_t sig(q20_t z);
    logic [19:0] y;
    logic [15:0] f;
    y = z[19] ? (~$unsigned(z) + 20'd1) : $unsigned(z);
    if (y >= 20'd81920)      f = 16'd16384;
    else if (y >= 20'd38912) f = 16'(y >> 5) + 16'd13824;
    else if (y >= 20'd16384) f = 16'(y >> 3) + 16'd10240;
    else                     f = 16'(y >> 2) + 16'd8192;
    if (z[19]) f = 16'd16384 - f;
    return q16_t'(f);
  endfunction

  state_t         state_q, state_d;
  q16_t           x_q[2], x_d[2];
  logic           train_q, train_d;
  q16_t           w1_q[2][2], w1_d[2][2];
  q16_t           w2_q[2][2], w2_d[2][2];
  q16_t           b1_q[2], b1_d[2];
  q16_t           b2_q[2], b2_d[2];
  q20_t           z2_q[2], z2_d[2];
  q20_t           z3_q[2], z3_d[2];
  q16_t           a2_q[2], a2_d[2];
  q16_t           a3_q[2], a3_d[2];
  q16_t           e_q[2], e_d[2];
  q16_t           p3_q[2], p3_d[2];
  q16_t           d3_q[2], d3_d[2];
  q16_t           p2_q[2], p2_d[2];
  q16_t           d2_q[2], d2_d[2];
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           fin_q, fin_d;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    train_d = train_q;
    w1_d    = w1_q;
    w2_d    = w2_q;
    b1_d    = b1_q;
    b2_d    = b2_q;
    z2_d    = z2_q;
    z3_d    = z3_q;
    a2_d    = a2_q;
    a3_d    = a3_q;
    e_d     = e_q;
    p3_d    = p3_q;
    d3_d    = d3_q;
    p2_d    = p2_q;
    d2_d    = d2_q;
    cnt_d   = cnt_q;
    fin_d   = fin_q;
    unique case (state_q)
      S0_LOAD: begin
        x_d[0]  = q16_t'(host.input_k_1);
        x_d[1]  = q16_t'(host.input_k_2);
        train_d = host.update_coeff;
        state_d = S1_Z2;
      end
      S1_Z2: begin
        for (int j = 0; j < 2; j++)
          z2_d[j] = add3(mulq(w1_q[j][0], x_q[0]), mulq(w1_q[j][1], x_q[1]), ext(b1_q[j]));
        state_d = S2_A2;
      end
      S2_A2: begin
        for (int j = 0; j < 2; j++) a2_d[j] = sig(z2_q[j]);
        state_d = S3_Z3;
      end
      S3_Z3: begin
        for (int k = 0; k < 2; k++)
          z3_d[k] = add3(mulq(w2_q[k][0], a2_q[0]), mulq(w2_q[k][1], a2_q[1]), ext(b2_q[k]));
        state_d = S4_A3;
      end
      S4_A3: begin
        for (int k = 0; k < 2; k++) a3_d[k] = sig(z3_q[k]);
        state_d = S5_ERR;
      end
      S5_ERR: begin
        e_d[0]  = n16(sub2(ext(a3_q[0]), ext(T1)));
        e_d[1]  = n16(sub2(ext(a3_q[1]), ext(T2)));
        state_d = S6_D3P;
      end
      S6_D3P: begin
        for (int k = 0; k < 2; k++)
          p3_d[k] = n16(mulq(a3_q[k], n16(sub2(ext(ONE), ext(a3_q[k])))));
        state_d = S7_D3;
      end
      S7_D3: begin
        for (int k = 0; k < 2; k++) d3_d[k] = n16(mulq(e_q[k], p3_q[k]));
        state_d = S8_D2P;
      end
      S8_D2P: begin
        for (int j = 0; j < 2; j++)
          p2_d[j] = n16(mulq(a2_q[j], n16(sub2(ext(ONE), ext(a2_q[j])))));
        state_d = S9_D2;
      end
      S9_D2: begin
        // W2 is still the pre-update value here; it is only written in S10
        for (int j = 0; j < 2; j++)
          d2_d[j] = n16(mulq(n16(add3(mulq(w2_q[0][j], d3_q[0]), mulq(w2_q[1][j], d3_q[1]), 20'sd0)),
                             p2_q[j]));
        state_d = S10_UW2;
      end
      S10_UW2: begin
        if (train_q) begin
          for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 2; j++)
              w2_d[k][j] = n16(sub2(ext(w2_q[k][j]), mulq(d3_q[k], a2_q[j]) >>> LR_SHIFT));
            b2_d[k] = n16(sub2(ext(b2_q[k]), ext(d3_q[k]) >>> LR_SHIFT));
          end
        end
        state_d = S11_UW1;
      end
      S11_UW1: begin
        if (train_q) begin
          for (int j = 0; j < 2; j++) begin
            for (int i = 0; i < 2; i++)
              w1_d[j][i] = n16(sub2(ext(w1_q[j][i]), mulq(d2_q[j], x_q[i]) >>> LR_SHIFT));
            b1_d[j] = n16(sub2(ext(b1_q[j]), ext(d2_q[j]) >>> LR_SHIFT));
          end
        end
        state_d = S12_CHK;
      end
      S12_CHK: begin
        state_d = S0_LOAD;
        if (train_q) begin
          cnt_d = cnt_q + CW'(1);
          if ((add3(absq(e_q[0]), absq(e_q[1]), 20'sd0) < ext(ERR_TH)) ||
              (cnt_d == CW'(MAX_ITER))) begin
            state_d = S13_DONE;
            fin_d   = 1'b1;
          end
        end
      end
      S13_DONE: state_d = S13_DONE;
      default:  state_d = S0_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= S0_LOAD;
      x_q     <= '{default: '0};
      train_q <= 1'b0;
      w1_q    <= '{'{16'sh2000, 16'shF000}, '{16'sh1000, 16'sh2000}};
      w2_q    <= '{'{16'sh2000, 16'sh2000}, '{16'shE000, 16'sh2000}};
      b1_q    <= '{default: '0};
      b2_q    <= '{default: '0};
      z2_q    <= '{default: '0};
      z3_q    <= '{default: '0};
      a2_q    <= '{default: '0};
      a3_q    <= '{default: '0};
      e_q     <= '{default: '0};
      p3_q    <= '{default: '0};
      d3_q    <= '{default: '0};
      p2_q    <= '{default: '0};
      d2_q    <= '{default: '0};
      cnt_q   <= '0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      train_q <= train_d;
      w1_q    <= w1_d;
      w2_q    <= w2_d;
      b1_q    <= b1_d;
      b2_q    <= b2_d;
      z2_q    <= z2_d;
      z3_q    <= z3_d;
      a2_q    <= a2_d;
      a3_q    <= a3_d;
      e_q     <= e_d;
      p3_q    <= p3_d;
      d3_q    <= d3_d;
      p2_q    <= p2_d;
      d2_q    <= d2_d;
      cnt_q   <= cnt_d;
      fin_q   <= fin_d;
    end
  end

  assign host.a3_1            = a3_q[0];
  assign host.a3_2            = a3_q[1];
  assign host.finish_updating = fin_q;

endmodule

// File: tb/tb_nn_backprop_core.sv
// tb/tb_nn_backprop_core.sv - randomized self-checking bench for nn_backprop_core against an iteration-level model
module tb_nn_backprop_core;
  localparam int ONE = 16384;

  logic clk = 1'b0;
  logic res = 1'b1;
  always #5 clk = ~clk;

  nn_backprop_core_if bus();
  nn_backprop_core dut (.clk(clk), .res(res), .host(bus));

  int n_pass  = 0;
  int n_total = 0;

  int mw1[4], mb1[2], mw2[4], mb2[2], m_a3[2], m_cnt;
  bit m_done;

  function automatic int w20(longint v);
    logic signed [19:0] t;
    t = v[19:0];
    return t;
  endfunction

  function automatic int w16(longint v);
    logic signed [15:0] t;
    t = v[15:0];
    return t;
  endfunction

  function automatic int mq(int a, int b);
    return w20((longint'(a) * longint'(b)) >>> 14);
  endfunction

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int sig(int z);
    int y, f;
    y = iabs(z);
    if (y >= 81920)      f = ONE;
    else if (y >= 38912) f = y / 32 + 13824;
    else if (y >= 16384) f = y / 8 + 10240;
    else                 f = y / 4 + 8192;
    return (z < 0) ? ONE - f : f;
  endfunction

  task automatic model_reset();
    mw1 = '{8192, -4096, 4096, 8192};
    mw2 = '{8192, 8192, -8192, 8192};
    mb1 = '{0, 0};
    mb2 = '{0, 0};
    m_a3 = '{0, 0};
    m_cnt = 0;
    m_done = 1'b0;
  endtask

  // One full forward/backward/update pass; weights indexed [2*row + col]
  task automatic model_iter(input logic [15:0] x1, input logic [15:0] x2, input bit train);
    int x[2], a2[2], a3[2], e[2], d3[2], d2[2], t[2];
    if (m_done) return;
    x[0] = w16(x1);
    x[1] = w16(x2);
    t = '{12288, 4096};
    for (int j = 0; j < 2; j++)
      a2[j] = sig(w20(mq(mw1[2*j], x[0]) + mq(mw1[2*j+1], x[1]) + mb1[j]));
    for (int k = 0; k < 2; k++) begin
      a3[k] = sig(w20(mq(mw2[2*k], a2[0]) + mq(mw2[2*k+1], a2[1]) + mb2[k]));
      e[k]  = w16(a3[k] - t[k]);
      d3[k] = w16(mq(e[k], w16(mq(a3[k], ONE - a3[k]))));
    end
    for (int j = 0; j < 2; j++)
      d2[j] = w16(mq(w16(mq(mw2[j], d3[0]) + mq(mw2[2+j], d3[1])), w16(mq(a2[j], ONE - a2[j]))));
    m_a3 = a3;
    if (train) begin
      for (int k = 0; k < 2; k++) begin
        for (int j = 0; j < 2; j++) mw2[2*k+j] = w16(mw2[2*k+j] - (mq(d3[k], a2[j]) >>> 2));
        mb2[k] = w16(mb2[k] - (d3[k] >>> 2));
      end
      for (int j = 0; j < 2; j++) begin
        for (int i = 0; i < 2; i++) mw1[2*j+i] = w16(mw1[2*j+i] - (mq(d2[j], x[i]) >>> 2));
        mb1[j] = w16(mb1[j] - (d2[j] >>> 2));
      end
      m_cnt++;
      if ((iabs(e[0]) + iabs(e[1]) < 256) || (m_cnt == 10000)) m_done = 1'b1;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    res = 1'b1;
    @(negedge clk);
    res = 1'b0;
  endtask

  task automatic drive(input logic [15:0] x1, input logic [15:0] x2, input logic uc);
    bus.input_k_1 = x1;
    bus.input_k_2 = x2;
    bus.update_coeff = uc;
  endtask

  task automatic test_reset();
    drive(16'h2000, 16'h2000, 1'b1);
    res = 1'b1;
    tick(2);
    n_total++;
    if ({bus.a3_1, bus.a3_2, bus.finish_updating} !== {16'h0000, 16'h0000, 1'b0})
      $display("FAIL reset_state: a3_1=%h a3_2=%h finish=%b, want 0000 0000 0", bus.a3_1, bus.a3_2, bus.finish_updating);
    else n_pass++;
  endtask

  task automatic test_first_iteration();
    drive(16'h2000, 16'h2000, 1'b1);
    do_reset();
    tick(4);
    n_total++;
    if ({bus.a3_1, bus.a3_2} !== 32'h0)
      $display("FAIL a3_before_edge5: a3_1=%h a3_2=%h, want 0000 0000", bus.a3_1, bus.a3_2);
    else n_pass++;
    tick(1);
    n_total++;
    if ({bus.a3_1, bus.a3_2, bus.finish_updating} !== {16'h2900, 16'h2080, 1'b0})
      $display("FAIL a3_at_edge5: a3_1=%h a3_2=%h finish=%b, want 2900 2080 0", bus.a3_1, bus.a3_2, bus.finish_updating);
    else n_pass++;
  endtask

  task automatic test_input_sampling();
    logic [15:0] a1, a2v, b1, b2;
    a1 = 16'($urandom); a2v = 16'($urandom); b1 = 16'($urandom); b2 = 16'($urandom);
    model_reset();
    model_iter(a1, a2v, 1'b0);
    drive(a1, a2v, 1'b0);
    do_reset();
    tick(1);
    @(negedge clk);
    drive(b1, b2, 1'b1);
    tick(4);
    n_total++;
    if ({bus.a3_1, bus.a3_2} !== {16'(m_a3[0]), 16'(m_a3[1])})
      $display("FAIL sample_only_s0: a3_1=%h a3_2=%h, want %h %h", bus.a3_1, bus.a3_2, 16'(m_a3[0]), 16'(m_a3[1]));
    else n_pass++;
    model_iter(b1, b2, 1'b1);
    tick(13);
    n_total++;
    if ({bus.a3_1, bus.a3_2} !== {16'(m_a3[0]), 16'(m_a3[1])})
      $display("FAIL next_iter_inputs: a3_1=%h a3_2=%h, want %h %h", bus.a3_1, bus.a3_2, 16'(m_a3[0]), 16'(m_a3[1]));
    else n_pass++;
  endtask

  task automatic test_inference();
    logic [15:0] x1, x2;
    for (int v = 0; v < 4; v++) begin
      x1 = 16'($urandom); x2 = 16'($urandom);
      model_reset();
      drive(x1, x2, 1'b0);
      do_reset();
      tick(5);
      for (int it = 0; it < 3; it++) begin
        model_iter(x1, x2, 1'b0);
        n_total++;
        if ({bus.a3_1, bus.a3_2, bus.finish_updating} !== {16'(m_a3[0]), 16'(m_a3[1]), 1'b0})
          $display("FAIL inference_rand v%0d it%0d: a3_1=%h a3_2=%h finish=%b, want %h %h 0",
                   v, it, bus.a3_1, bus.a3_2, bus.finish_updating, 16'(m_a3[0]), 16'(m_a3[1]));
        else n_pass++;
        tick(13);
      end
    end
    drive(16'h2000, 16'h2000, 1'b0);
    do_reset();
    tick(5);
    for (int it = 0; it < 77; it++) begin
      n_total++;
      if ({bus.a3_1, bus.a3_2, bus.finish_updating} !== {16'h2900, 16'h2080, 1'b0})
        $display("FAIL inference_fixed it%0d: a3_1=%h a3_2=%h finish=%b, want 2900 2080 0",
                 it, bus.a3_1, bus.a3_2, bus.finish_updating);
      else n_pass++;
      tick(13);
    end
  endtask

  task automatic test_train_random();
    logic [15:0] x1, x2;
    for (int v = 0; v < 3; v++) begin
      x1 = 16'($urandom); x2 = 16'($urandom);
      model_reset();
      drive(x1, x2, 1'b1);
      do_reset();
      tick(5);
      for (int it = 0; it < 6; it++) begin
        model_iter(x1, x2, 1'b1);
        n_total++;
        if ({bus.a3_1, bus.a3_2} !== {16'(m_a3[0]), 16'(m_a3[1])})
          $display("FAIL train_a3 v%0d it%0d: a3_1=%h a3_2=%h, want %h %h",
                   v, it, bus.a3_1, bus.a3_2, 16'(m_a3[0]), 16'(m_a3[1]));
        else n_pass++;
        tick(8);
        n_total++;
        if (bus.finish_updating !== m_done)
          $display("FAIL train_finish v%0d it%0d: finish=%b, want %b", v, it, bus.finish_updating, m_done);
        else n_pass++;
        tick(5);
      end
    end
  endtask

  task automatic test_midrun_reset();
    int k;
    k = int'($urandom_range(1, 3));
    drive(16'h2000, 16'h2000, 1'b1);
    do_reset();
    tick(13 * k + 7);
    do_reset();
    tick(4);
    n_total++;
    if ({bus.a3_1, bus.a3_2, bus.finish_updating} !== {16'h0000, 16'h0000, 1'b0})
      $display("FAIL midrun_reset_clear: a3_1=%h a3_2=%h finish=%b, want 0000 0000 0", bus.a3_1, bus.a3_2, bus.finish_updating);
    else n_pass++;
    tick(1);
    n_total++;
    if ({bus.a3_1, bus.a3_2} !== {16'h2900, 16'h2080})
      $display("FAIL midrun_reset_rerun: a3_1=%h a3_2=%h, want 2900 2080", bus.a3_1, bus.a3_2);
    else n_pass++;
  endtask

  task automatic test_train_to_finish();
    int cyc, bound, err;
    model_reset();
    while (!m_done) model_iter(16'h2000, 16'h2000, 1'b1);
    bound = 13 * m_cnt + 100;
    drive(16'h2000, 16'h2000, 1'b1);
    do_reset();
    cyc = 0;
    while (bus.finish_updating !== 1'b1 && cyc < bound) begin
      tick(1);
      cyc++;
    end
    n_total++;
    if (cyc !== 13 * m_cnt)
      $display("FAIL finish_cycle: finish seen after %0d cycles, want %0d", cyc, 13 * m_cnt);
    else n_pass++;
    n_total++;
    if ({bus.a3_1, bus.a3_2} !== {16'(m_a3[0]), 16'(m_a3[1])})
      $display("FAIL final_a3: a3_1=%h a3_2=%h, want %h %h", bus.a3_1, bus.a3_2, 16'(m_a3[0]), 16'(m_a3[1]));
    else n_pass++;
    err = iabs(int'(bus.a3_1) - 12288) + iabs(int'(bus.a3_2) - 4096);
    n_total++;
    if (!(err < 256 || m_cnt == 10000))
      $display("FAIL convergence: error=%0d iterations=%0d, want error<256 or 10000 iterations", err, m_cnt);
    else n_pass++;
  endtask

  task automatic test_after_finish();
    for (int r = 0; r < 10; r++) begin
      @(negedge clk);
      drive(16'($urandom), 16'($urandom), 1'($urandom));
      tick(13 + int'($urandom_range(0, 12)));
      n_total++;
      if ({bus.a3_1, bus.a3_2, bus.finish_updating} !== {16'(m_a3[0]), 16'(m_a3[1]), 1'b1})
        $display("FAIL frozen_after_finish r%0d: a3_1=%h a3_2=%h finish=%b, want %h %h 1",
                 r, bus.a3_1, bus.a3_2, bus.finish_updating, 16'(m_a3[0]), 16'(m_a3[1]));
      else n_pass++;
    end
  endtask

  initial begin
    drive(16'h0000, 16'h0000, 1'b0);
    test_reset();
    test_first_iteration();
    test_input_sampling();
    test_inference();
    test_train_random();
    test_midrun_reset();
    test_train_to_finish();
    test_after_finish();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
